fsk_modulation: RTL and testbench

- Binary FSK transmitter for the fsk_demodulation datapath. Accepts one data bit at a time over a valid/ready handshake.
- Emits a signed 11-bit sine sample stream at the sample rate: frequency f1 for bit 0, f2 for bit 1.
- Uses a phase-accumulator NCO with a quarter-wave sine ROM. The output feeds the demodulator's sample input and the DAC path.

---
 rtl/fsk_pkg.sv | 29 ++
 rtl/fsk_sine_lut.sv | 43 ++++
 rtl/fsk_modulation.sv | 167 ++++++++++++++++
 tb/tb_fsk_modulation.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
// fsk_pkg: constants and types shared by the FSK transmitter (and the
// demodulator's reference tables).
//   DATA_W    : sample width, signed two's complement, peak +/-1023
//   LUT_AW    : full-wave LUT index width (top LUT_AW bits of phase)
//   QTR_AW    : quarter-wave table address width (LUT_AW - 2)
//   fsk_state_e : transmitter FSM encoding (IDLE=0, SEND=1)
//   SINE_QTR  : T[k] = round(1023*sin(2*pi*(k+0.5)/128)), k = 0..31.
//               The half-step offset keeps every entry non-zero, so the
//               mirrored full wave never produces 0 or -1024.
package fsk_pkg;

    localparam int DATA_W = 11;
    localparam int LUT_AW = 7;
    localparam int QTR_AW = LUT_AW - 2;
    localparam int QTR_N  = 1 << QTR_AW;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } fsk_state_e;

    localparam logic [DATA_W-1:0] SINE_QTR [QTR_N] = '{
        11'd25,   11'd75,   11'd125,  11'd175,  11'd224,  11'd273,  11'd321,  11'd368,
        11'd415,  11'd460,  11'd504,  11'd547,  11'd589,  11'd629,  11'd668,  11'd705,
        11'd741,  11'd775,  11'd806,  11'd836,  11'd864,  11'd890,  11'd914,  11'd935,
        11'd954,  11'd971,  11'd986,  11'd998,  11'd1008, 11'd1015, 11'd1020, 11'd1023
    };

endpackage

// File: rtl/fsk_sine_lut.sv
// fsk_sine_lut: full-wave sine lookup built from the quarter-wave table,
// with one register stage on the output.
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low
//   idx    : LUT_AW-bit phase index {quadrant[1:0], addr[QTR_AW-1:0]}
//   sample : registered signed DATA_W sample
// Quadrant mirroring: q0 T[a], q1 T[31-a], q2 -T[a], q3 -T[31-a].
module fsk_sine_lut
    import fsk_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LUT_AW-1:0]        idx,
    output logic signed [DATA_W-1:0] sample
);

    logic [QTR_AW-1:0]        addr;
    logic signed [DATA_W-1:0] mag;
    logic signed [DATA_W-1:0] sample_d;
    logic signed [DATA_W-1:0] sample_q;

    always_comb begin
        addr     = idx[QTR_AW-1:0];
        // Odd quadrants run the table backwards; 31-a equals ~a for 5 bits.
        if (idx[QTR_AW]) begin
            addr = ~idx[QTR_AW-1:0];
        end
        mag      = $signed(SINE_QTR[addr]);
        // Lower half of the wave is the negated upper half.
        sample_d = idx[LUT_AW-1] ? -mag : mag;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_q <= '0;
        end else begin
            sample_q <= sample_d;
        end
    end

    assign sample = sample_q;

endmodule

// File: rtl/fsk_modulation.sv
// fsk_modulation: binary FSK transmitter. One data bit is accepted per
// handshake and sent as SPB samples of a phase-accumulator NCO sine, using
// increment PINC_F1 for bit 0 and PINC_F2 for bit 1. One sample is produced
// every SAMPLE_DIV clocks.
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-low
//   data_bit     : bit to transmit
//   bit_valid    : data_bit valid
//   bit_ready    : bit accepted on a cycle with bit_valid && bit_ready
//   fsk_mod      : signed DATA_W modulated sample (holds between updates)
//   sample_valid : one-cycle strobe when fsk_mod updates
//   busy         : high while in SEND (doubles as the FSM state view)
// Build option: define FSK_PHASE_RESET_EN to clear the phase accumulator on
// every bit acceptance; without it the phase is continuous across bits and
// idle gaps and is only cleared by reset.
//
// Handshake: a bit transfers on a rising edge where bit_valid && bit_ready.
// bit_ready is combinational: always 1 in IDLE, and in SEND only on the
// sample tick that ends the current bit, so back-to-back bits have no gap.
// bit_valid at any other time during SEND is ignored.
module fsk_modulation
    import fsk_pkg::*;
#(
    parameter int PHASE_W    = 16,
    parameter int SAMPLE_DIV = 800,
    parameter int SPB        = 8,
    parameter int PINC_F1    = 512,
    parameter int PINC_F2    = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     data_bit,
    input  logic                     bit_valid,
    output logic                     bit_ready,
    output logic signed [DATA_W-1:0] fsk_mod,
    output logic                     sample_valid,
    output logic                     busy
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int SMP_W = (SPB > 1) ? $clog2(SPB) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [SMP_W-1:0]   SMP_LAST = SMP_W'(SPB - 1);
    localparam logic [PHASE_W-1:0] PINC1    = PHASE_W'(PINC_F1);
    localparam logic [PHASE_W-1:0] PINC2    = PHASE_W'(PINC_F2);

    fsk_state_e          state_q,   state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [SMP_W-1:0]    smp_cnt_q, smp_cnt_d;
    logic [PHASE_W-1:0]  phase_q,   phase_d;
    logic                cur_bit_q, cur_bit_d;

    logic                tick;
    logic                last_smp;
    logic [PHASE_W-1:0]  phase_step;

    // Sample pipeline: LUT register, then the output register.
    logic                     tick_dly_q,     tick_dly_d;
    logic                     sample_valid_q, sample_valid_d;
    logic signed [DATA_W-1:0] fsk_mod_q,      fsk_mod_d;
    logic signed [DATA_W-1:0] lut_sample;

    // ------------------------------------------------------------------
    // FSM, counters and phase accumulator
    // ------------------------------------------------------------------
    always_comb begin
        tick       = (state_q == SEND) && (div_cnt_q == DIV_LAST);
        last_smp   = (smp_cnt_q == SMP_LAST);
        bit_ready  = (state_q == IDLE) || (tick && last_smp);
        // Phase of the sample being generated on this tick; also the LUT
        // index source, so the LUT sees the updated phase.
        phase_step = phase_q + (cur_bit_q ? PINC2 : PINC1);

        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        smp_cnt_d = smp_cnt_q;
        phase_d   = phase_q;
        cur_bit_d = cur_bit_q;

        case (state_q)
            IDLE: begin
                if (bit_valid) begin
                    cur_bit_d = data_bit;
                    state_d   = SEND;
                    div_cnt_d = '0;
                    smp_cnt_d = '0;
`ifdef FSK_PHASE_RESET_EN
                    phase_d   = '0;
`endif
                end
            end
            SEND: begin
                div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
                if (tick) begin
                    phase_d = phase_step;
                    if (last_smp) begin
                        smp_cnt_d = '0;
                        if (bit_valid) begin
                            cur_bit_d = data_bit;
`ifdef FSK_PHASE_RESET_EN
                            // The last sample of the old bit already took
                            // phase_step; the new bit starts from zero.
                            phase_d   = '0;
`endif
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + SMP_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            smp_cnt_q <= '0;
            phase_q   <= '0;
            cur_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            smp_cnt_q <= smp_cnt_d;
            phase_q   <= phase_d;
            cur_bit_q <= cur_bit_d;
        end
    end

    // ------------------------------------------------------------------
    // Sample path: the LUT registers every cycle; the output stage only
    // loads the value the LUT captured on a tick edge.
    // ------------------------------------------------------------------
    fsk_sine_lut u_lut (
        .clk    (clk),
        .reset  (reset),
        .idx    (phase_step[PHASE_W-1 -: LUT_AW]),
        .sample (lut_sample)
    );

    always_comb begin
        tick_dly_d     = tick;
        sample_valid_d = tick_dly_q;
        fsk_mod_d      = tick_dly_q ? lut_sample : fsk_mod_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_dly_q     <= 1'b0;
            sample_valid_q <= 1'b0;
            fsk_mod_q      <= '0;
        end else begin
            tick_dly_q     <= tick_dly_d;
            sample_valid_q <= sample_valid_d;
            fsk_mod_q      <= fsk_mod_d;
        end
    end

    assign fsk_mod      = fsk_mod_q;
    assign sample_valid = sample_valid_q;
    assign busy         = (state_q == SEND);

endmodule

// File: tb/tb_fsk_modulation.sv
// tb_fsk_modulation: self-checking bench for fsk_modulation with
// SAMPLE_DIV=4, SPB=8. Expected samples come from a floating-point sine
// model of the phase accumulator; pulse timing is derived from the
// acceptance cycle.
module tb_fsk_modulation;

    localparam int  D   = 4;
    localparam int  SPB = 8;
    localparam int  F1  = 512;
    localparam int  F2  = 1024;
    localparam real PI  = 3.14159265358979;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               data_bit = 1'b0;
    logic               bit_valid = 1'b0;
    logic               bit_ready;
    logic signed [10:0] fsk_mod;
    logic               sample_valid;
    logic               busy;

    fsk_modulation #(
        .PHASE_W    (16),
        .SAMPLE_DIV (D),
        .SPB        (SPB),
        .PINC_F1    (F1),
        .PINC_F2    (F2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_bit     (data_bit),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .fsk_mod      (fsk_mod),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          pass_cnt  = 0;
    int          check_cnt = 0;
    logic [10:0] exp_q[$];
    int          got_q[$];
    int          pulse_cyc[$];
    int          m_phase = 0;
    logic [10:0] mon_e;

    task automatic check(input string name, input int act, input int exp);
        check_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference sine at full-wave index idx: round half away from zero.
    function automatic int ref_sine(input int idx);
        real x;
        x = 1023.0 * $sin(2.0 * PI * (real'(idx) + 0.5) / 128.0);
        if (x >= 0.0) return $rtoi(x + 0.5);
        else          return -$rtoi(-x + 0.5);
    endfunction

    // Model of one transmitted bit: SPB phase steps, one sample per step.
    task automatic model_bit(input logic b);
`ifdef FSK_PHASE_RESET_EN
        m_phase = 0;
`endif
        for (int s = 0; s < SPB; s++) begin
            m_phase = (m_phase + (b ? F2 : F1)) % 65536;
            exp_q.push_back(11'(ref_sine(m_phase / 512)));
        end
    endtask

    // Monitor: every sample_valid pulse is compared with the next expectation.
    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            got_q.push_back(int'(fsk_mod));
            pulse_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_sample", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sample_value", int'(fsk_mod), int'($signed(mon_e)));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        bit_valid = 1'b0;
        data_bit  = 1'b0;
        reset     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        m_phase = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        for (int g = 0; g < 2000 && exp_q.size() != 0; g++) @(negedge clk);
        check({tag, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (D + 4) @(negedge clk);
    endtask

    // Send n bits back to back (bit_valid held), then check count, pulse
    // timing and the return to idle.
    task automatic send_bits(input int n, input logic [63:0] bits, input string tag);
        int acc;
        int acc0;
        int guard;
        int limit;
        for (int i = 0; i < n; i++) model_bit(bits[i]);
        got_q.delete();
        pulse_cyc.delete();
        @(posedge clk);
        #1;
        data_bit  = bits[0];
        bit_valid = 1'b1;
        acc0      = cyc + 1;
        acc       = 0;
        guard     = 0;
        limit     = n * D * SPB + 20;
        while (acc < n && guard < limit) begin
            @(negedge clk);
            guard++;
            if (bit_ready) begin
                @(posedge clk);
                #1;
                acc++;
                if (acc < n) data_bit = bits[acc];
                else         bit_valid = 1'b0;
            end
        end
        bit_valid = 1'b0;
        check({tag, "_accepted"}, acc, n);
        wait_drain(tag);
        check({tag, "_count"}, got_q.size(), n * SPB);
        // Sample k of the burst: tick ends D*(k+1) cycles after acceptance,
        // the strobe appears two clocks after the tick cycle.
        for (int k = 0; k < pulse_cyc.size(); k++)
            check({tag, "_pulse_time"}, pulse_cyc[k], acc0 + D + 1 + D * k);
        check({tag, "_busy_after"}, int'(busy), 0);
        check({tag, "_ready_after"}, int'(bit_ready), 1);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int         n;
        logic [7:0] bits;      // bits[i] is the i-th bit sent
        int         exp_first; // sample 0
        int         exp_mid;   // sample SPB (first sample of bit 2)
        int         exp_last;  // final sample
    } vec_t;

    vec_t vecs[4];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int first;
        int mx;
        int mn;
        int bad;
        int n;
        logic [63:0] rbits;

`ifdef FSK_PHASE_RESET_EN
        vecs[0] = '{1, 8'b00, 75,  0,   415};
        vecs[1] = '{1, 8'b01, 125, 0,   741};
        vecs[2] = '{2, 8'b10, 75,  125, 741};
        vecs[3] = '{2, 8'b01, 125, 75,  415};
`else
        vecs[0] = '{1, 8'b00, 75,  0,   415};
        vecs[1] = '{1, 8'b01, 125, 0,   741};
        vecs[2] = '{2, 8'b10, 75,  504, 954};
        vecs[3] = '{2, 8'b01, 125, 775, 954};
`endif

        // Reset then idle.
        apply_reset();
        got_q.delete();
        repeat (20) @(negedge clk);
        check("idle_fsk_mod", int'(fsk_mod), 0);
        check("idle_sample_valid", int'(sample_valid), 0);
        check("idle_bit_ready", int'(bit_ready), 1);
        check("idle_busy", int'(busy), 0);
        check("idle_no_samples", got_q.size(), 0);

        // Table-driven single and back-to-back bits from reset.
        foreach (vecs[r]) begin
            apply_reset();
            send_bits(vecs[r].n, 64'(vecs[r].bits), $sformatf("vec%0d", r));
            first = (got_q.size() > 0) ? got_q[0] : 9999;
            check($sformatf("vec%0d_first", r), first, vecs[r].exp_first);
            if (vecs[r].n > 1)
                check($sformatf("vec%0d_mid", r),
                      (got_q.size() > SPB) ? got_q[SPB] : 9999, vecs[r].exp_mid);
            check($sformatf("vec%0d_last", r),
                  (got_q.size() > 0) ? got_q[got_q.size() - 1] : 9999, vecs[r].exp_last);
        end

        // bit_valid mid-bit is ignored.
        apply_reset();
        model_bit(1'b0);
        got_q.delete();
        @(posedge clk);
        #1;
        data_bit  = 1'b0;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        data_bit = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ready_mid_bit", int'(bit_ready), 0);
        end
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        wait_drain("ignore");
        check("ignore_count", got_q.size(), SPB);

        // Reset mid-bit: outputs clear at once, no further samples, phase 0.
        apply_reset();
        model_bit(1'b1);
        got_q.delete();
        @(posedge clk);
        #1;
        data_bit  = 1'b1;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        for (int g = 0; g < 200 && got_q.size() < 3; g++) @(negedge clk);
        check("abort_reached_3rd", got_q.size(), 3);
        #2;
        reset = 1'b0;
        #1;
        check("abort_fsk_mod", int'(fsk_mod), 0);
        check("abort_sample_valid", int'(sample_valid), 0);
        check("abort_busy", int'(busy), 0);
        exp_q.delete();
        m_phase = 0;
        got_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (D * SPB) @(negedge clk);
        check("abort_no_samples", got_q.size(), 0);
        send_bits(1, 64'h0, "restart");
        check("restart_first", (got_q.size() > 0) ? got_q[0] : 9999, 75);

        // Full-cycle symmetry: 16 zero bits cover all 128 indices.
        apply_reset();
        send_bits(16, 64'h0, "sym");
        if (got_q.size() == 128) begin
            mx  = -5000;
            mn  = 5000;
            bad = 0;
            for (int j = 0; j < 64; j++)
                check("sym_negative", got_q[j], -got_q[j + 64]);
            foreach (got_q[j]) begin
                if (got_q[j] > mx) mx = got_q[j];
                if (got_q[j] < mn) mn = got_q[j];
                if (got_q[j] == 0 || got_q[j] == -1024) bad++;
            end
            check("sym_peak_pos", mx, 1023);
            check("sym_peak_neg", mn, -1023);
            check("sym_no_zero_or_min", bad, 0);
        end

        // Randomized bursts with idle gaps; phase carries across gaps.
        apply_reset();
        for (int b = 0; b < 8; b++) begin
            n     = $urandom_range(1, 3);
            rbits = 64'($urandom);
            send_bits(n, rbits, "rand");
            repeat ($urandom_range(0, 10)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
